// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single read port of one ROM between two requesters:
//   port 0 (core fetch/operand reads) and port 1 (loader/debug reader).
//   Only one ROM access is in flight at a time. Ties are broken round-robin,
//   or always in favour of port 0 when FIXED=1. Each completed access
//   produces a one-cycle valid pulse on the served port. The captured
//   data/error pair is shared by both ports.
//
// Ports
//   clk, reset            clock (rising edge) / asynchronous active-low reset
//   reqN                  read request, held by the requester until validN
//   addrN, extraN         read address and extra/size field for port N
//   loN, hiN              bounds forwarded to the ROM for port N
//   gntN                  one-cycle pulse: port N's request was issued to the ROM
//   validN                one-cycle pulse: data/error belong to port N
//   data, error           captured ROM result; held until the next capture
//   rom_addr, rom_extra,
//   rom_lower_bound,
//   rom_upper_bound       registered request presented to the ROM
//   rom_data, rom_error   ROM result, sampled LATENCY cycles after issue
module rom_port_arbiter #(
  parameter int AW      = 6,
  parameter int EXTRA   = 4,
  parameter int LATENCY = 1,
  parameter int FIXED   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      req1,
  input  logic [AW:0]               addr0,
  input  logic [AW:0]               addr1,
  input  logic [EXTRA-1:0]          extra0,
  input  logic [EXTRA-1:0]          extra1,
  input  logic [AW:0]               lo0,
  input  logic [AW:0]               lo1,
  input  logic [AW:0]               hi0,
  input  logic [AW:0]               hi1,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic                      valid0,
  output logic                      valid1,
  output logic [(2**EXTRA)*8-1:0]   data,
  output logic                      error,
  output logic [AW:0]               rom_addr,
  output logic [EXTRA-1:0]          rom_extra,
  output logic [AW:0]               rom_lower_bound,
  output logic [AW:0]               rom_upper_bound,
  input  logic [(2**EXTRA)*8-1:0]   rom_data,
  input  logic                      rom_error
);

  localparam int DW = (2**EXTRA)*8;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          IS_FIXED = (FIXED != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_r;
  logic             last_r;     // last port served; the other port wins a tie
  logic             served_r;   // port owning the in-flight access
  logic [CW-1:0]    cnt_r;

  logic             in_resp_s;
  logic             cand0_s;
  logic             cand1_s;
  logic             hold_s;
  logic             go_s;
  logic             pick_s;
  logic [AW:0]      sel_addr_s;
  logic [EXTRA-1:0] sel_extra_s;
  logic [AW:0]      sel_lo_s;
  logic [AW:0]      sel_hi_s;

  // Arbitration: choose the next port and the request fields to latch
  always_comb begin
    in_resp_s = (state_r == ST_RESP);
    // The served port still holds req during RESP; that request is already
    // satisfied, so it must not compete.
    cand0_s = req0 & ~(in_resp_s & ~served_r);
    cand1_s = req1 & ~(in_resp_s & served_r);
    // With fixed priority, port 1 must not slip in during RESP while port 0
    // still requests; port 0 is picked again from IDLE on the next cycle.
    hold_s = IS_FIXED & in_resp_s & ~served_r & req0;
    go_s   = (cand0_s | cand1_s) & ~hold_s;
    if (cand0_s && cand1_s) begin
      pick_s = IS_FIXED ? 1'b0 : ~last_r;
    end else begin
      pick_s = cand1_s;
    end
    sel_addr_s  = pick_s ? addr1  : addr0;
    sel_extra_s = pick_s ? extra1 : extra0;
    sel_lo_s    = pick_s ? lo1    : lo0;
    sel_hi_s    = pick_s ? hi1    : hi0;
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT -> RESP -> (ISSUE | IDLE)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      last_r          <= 1'b1;
      served_r        <= 1'b0;
      cnt_r           <= {CW{1'b0}};
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      valid0          <= 1'b0;
      valid1          <= 1'b0;
      data            <= {DW{1'b0}};
      error           <= 1'b0;
      rom_addr        <= {(AW+1){1'b0}};
      rom_extra       <= {EXTRA{1'b0}};
      rom_lower_bound <= {(AW+1){1'b0}};
      rom_upper_bound <= {(AW+1){1'b0}};
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (go_s) begin
            state_r         <= ST_ISSUE;
            served_r        <= pick_s;
            gnt0            <= ~pick_s;
            gnt1            <= pick_s;
            rom_addr        <= sel_addr_s;
            rom_extra       <= sel_extra_s;
            rom_lower_bound <= sel_lo_s;
            rom_upper_bound <= sel_hi_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_r   <= CNT_LOAD;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == {CW{1'b0}}) begin
            data    <= rom_data;
            error   <= rom_error;
            valid0  <= ~served_r;
            valid1  <= served_r;
            last_r  <= served_r;
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance: LATENCY=1, round-robin
  logic         req0, req1;
  logic [6:0]   addr0, addr1, lo0, lo1, hi0, hi1;
  logic [3:0]   extra0, extra1;
  logic         gnt0, gnt1, valid0, valid1, error;
  logic [127:0] data;
  logic [6:0]   rom_addr, rom_lower_bound, rom_upper_bound;
  logic [3:0]   rom_extra;
  logic [128:0] m_q;

  // LATENCY=3 instance
  logic         l3_req0;
  logic [6:0]   l3_addr0;
  logic         l3_gnt0, l3_gnt1, l3_valid0, l3_valid1, l3_error;
  logic [127:0] l3_data;
  logic [6:0]   l3_rom_addr, l3_rom_lo, l3_rom_hi;
  logic [3:0]   l3_rom_extra;
  logic [128:0] l3_p0, l3_p1, l3_p2;

  // FIXED=1 instance
  logic         fx_req0, fx_req1;
  logic         fx_gnt0, fx_gnt1, fx_valid0, fx_valid1, fx_error;
  logic [127:0] fx_data;
  logic [6:0]   fx_rom_addr, fx_rom_lo, fx_rom_hi;
  logic [3:0]   fx_rom_extra;
  logic [128:0] fx_q;
  logic         fx_mon;
  int           fx_g0_cnt, fx_g1_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       port;
    logic [7:0] b0;
    logic       err;
  } exp_t;
  exp_t sb[$];

  rom_port_arbiter #(.AW(6), .EXTRA(4), .LATENCY(1), .FIXED(0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .extra0(extra0), .extra1(extra1), .lo0(lo0), .lo1(lo1), .hi0(hi0), .hi1(hi1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .data(data), .error(error),
    .rom_addr(rom_addr), .rom_extra(rom_extra),
    .rom_lower_bound(rom_lower_bound), .rom_upper_bound(rom_upper_bound),
    .rom_data(m_q[127:0]), .rom_error(m_q[128])
  );

  rom_port_arbiter #(.AW(6), .EXTRA(4), .LATENCY(3), .FIXED(0)) dut_l3 (
    .clk(clk), .reset(reset),
    .req0(l3_req0), .req1(1'b0), .addr0(l3_addr0), .addr1(7'd0),
    .extra0(4'd0), .extra1(4'd0), .lo0(7'd0), .lo1(7'd0), .hi0(7'd127), .hi1(7'd127),
    .gnt0(l3_gnt0), .gnt1(l3_gnt1), .valid0(l3_valid0), .valid1(l3_valid1),
    .data(l3_data), .error(l3_error),
    .rom_addr(l3_rom_addr), .rom_extra(l3_rom_extra),
    .rom_lower_bound(l3_rom_lo), .rom_upper_bound(l3_rom_hi),
    .rom_data(l3_p2[127:0]), .rom_error(l3_p2[128])
  );

  rom_port_arbiter #(.AW(6), .EXTRA(4), .LATENCY(1), .FIXED(1)) dut_fx (
    .clk(clk), .reset(reset),
    .req0(fx_req0), .req1(fx_req1), .addr0(7'd1), .addr1(7'd2),
    .extra0(4'd0), .extra1(4'd0), .lo0(7'd0), .lo1(7'd0), .hi0(7'd127), .hi1(7'd127),
    .gnt0(fx_gnt0), .gnt1(fx_gnt1), .valid0(fx_valid0), .valid1(fx_valid1),
    .data(fx_data), .error(fx_error),
    .rom_addr(fx_rom_addr), .rom_extra(fx_rom_extra),
    .rom_lower_bound(fx_rom_lo), .rom_upper_bound(fx_rom_hi),
    .rom_data(fx_q[127:0]), .rom_error(fx_q[128])
  );

  // ROM image: byte i holds i; out-of-bounds address flags an error
  function automatic logic [128:0] rom_read(input logic [6:0] a, input logic [6:0] lo,
                                            input logic [6:0] hi);
    logic [128:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(a) + 8'(k);
    r[128] = (a < lo) || (a > hi);
    return r;
  endfunction

  // ROM models with the latency each instance expects
  always_ff @(posedge clk) begin
    m_q   <= rom_read(rom_addr, rom_lower_bound, rom_upper_bound);
    fx_q  <= rom_read(fx_rom_addr, fx_rom_lo, fx_rom_hi);
    l3_p0 <= rom_read(l3_rom_addr, l3_rom_lo, l3_rom_hi);
    l3_p1 <= l3_p0;
    l3_p2 <= l3_p1;
  end

  // Grant counters for the fixed-priority instance
  always_ff @(posedge clk) begin
    if (fx_mon) begin
      fx_g0_cnt <= fx_g0_cnt + 32'(fx_gnt0);
      fx_g1_cnt <= fx_g1_cnt + 32'(fx_gnt1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [6:0] a, input logic [6:0] lo,
                      input logic [6:0] hi);
    exp_t e;
    e.port = port;
    e.b0   = 8'(a);
    e.err  = (a < lo) || (a > hi);
    sb.push_back(e);
  endtask

  // Wait for the next valid pulse of the main instance and score it
  task automatic wait_resp(input int maxc, output int cyc);
    logic found;
    exp_t e;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < maxc) begin
      tick();
      cyc++;
      found = valid0 | valid1;
    end
    check("resp_timeout", {127'd0, found}, 128'd1);
    if (found) begin
      check("valid_excl", {127'd0, valid0 & valid1}, 128'd0);
      if (sb.size() == 0) begin
        check("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        check("resp_port", {127'd0, valid1}, {127'd0, e.port});
        check("resp_data", {120'd0, data[7:0]}, {120'd0, e.b0});
        check("resp_err", {127'd0, error}, {127'd0, e.err});
      end
    end
  endtask

  task automatic check_reset_outs();
    check("reset_ctl", {98'd0, gnt0, gnt1, valid0, valid1, error, rom_addr, rom_extra,
                        rom_lower_bound, rom_upper_bound}, 128'd0);
    check("reset_data", data, 128'd0);
    check("reset_other", {120'd0, l3_gnt0, l3_gnt1, l3_valid0, l3_valid1,
                          fx_gnt0, fx_gnt1, fx_valid0, fx_valid1}, 128'd0);
  endtask

  int c;

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = 7'd0; addr1 = 7'd0;
    extra0 = 4'd0; extra1 = 4'd0; lo0 = 7'd0; lo1 = 7'd0; hi0 = 7'd127; hi1 = 7'd127;
    l3_req0 = 1'b0; l3_addr0 = 7'd0; fx_req0 = 1'b0; fx_req1 = 1'b0;
    fx_mon = 1'b0; fx_g0_cnt = 0; fx_g1_cnt = 0;

    // Reset held with random requests: everything stays at zero
    for (int i = 0; i < 4; i++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      addr0 = 7'($urandom); addr1 = 7'($urandom);
      l3_req0 = 1'($urandom); fx_req0 = 1'($urandom); fx_req1 = 1'($urandom);
      tick();
      check_reset_outs();
    end
    req0 = 1'b0; req1 = 1'b0; l3_req0 = 1'b0; fx_req0 = 1'b0; fx_req1 = 1'b0;
    reset = 1'b1;
    tick();

    // Single request: gnt one edge after sampling, valid two edges later
    addr0 = 7'd33; req0 = 1'b1; push(1'b0, 7'd33, 7'd0, 7'd127);
    tick();
    check("t1_gnt", {126'd0, gnt0, gnt1}, 128'd2);
    wait_resp(10, c);
    check("t1_lat", 128'(c), 128'd2);
    req0 = 1'b0;
    tick();

    // Fresh reset: simultaneous requests, port 0 first, port 1 three cycles later
    reset = 1'b0; tick(); tick(); reset = 1'b1; tick();
    addr0 = 7'd5; addr1 = 7'd9; req0 = 1'b1; req1 = 1'b1;
    push(1'b0, 7'd5, 7'd0, 7'd127); push(1'b1, 7'd9, 7'd0, 7'd127);
    wait_resp(10, c);
    req0 = 1'b0;
    wait_resp(10, c);
    check("t2_gap", 128'(c), 128'd3);
    req1 = 1'b0;
    tick();

    // Both held for six accesses: alternating service, fixed instance serves port 0 only
    addr0 = 7'd17; addr1 = 7'd40;
    for (int i = 0; i < 6; i++) push(1'(i % 2), (i % 2 == 0) ? 7'd17 : 7'd40, 7'd0, 7'd127);
    req0 = 1'b1; req1 = 1'b1; fx_req0 = 1'b1; fx_req1 = 1'b1; fx_mon = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_resp(10, c);
      if (i > 0) check("t3_period", 128'(c), 128'd3);
    end
    req0 = 1'b0; req1 = 1'b0; fx_req0 = 1'b0; fx_req1 = 1'b0;
    repeat (4) tick();
    fx_mon = 1'b0;
    check("fx_gnt1_none", 128'(fx_g1_cnt), 128'd0);
    check("fx_gnt0_some", {127'd0, fx_g0_cnt >= 3}, 128'd1);

    // Bounds: out of range flags error, upper boundary is still in range
    lo1 = 7'd0; hi1 = 7'd10; addr1 = 7'd20; req1 = 1'b1; push(1'b1, 7'd20, 7'd0, 7'd10);
    wait_resp(10, c);
    req1 = 1'b0; tick();
    addr1 = 7'd10; req1 = 1'b1; push(1'b1, 7'd10, 7'd0, 7'd10);
    wait_resp(10, c);
    req1 = 1'b0; hi1 = 7'd127; tick();

    // Reset during WAIT: no valid, no replay; next access is normal
    addr0 = 7'd40; req0 = 1'b1;
    tick();
    check("t5_gnt", {127'd0, gnt0}, 128'd1);
    tick();
    reset = 1'b0;
    tick();
    check_reset_outs();
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_valid", {126'd0, valid0, valid1}, 128'd0);
    end
    addr0 = 7'd50; req0 = 1'b1; push(1'b0, 7'd50, 7'd0, 7'd127);
    tick();
    check("t5b_gnt", {127'd0, gnt0}, 128'd1);
    addr0 = 7'd3;
    wait_resp(10, c);
    check("t5b_lat", 128'(c), 128'd2);
    req0 = 1'b0;
    tick();

    // LATENCY=3 instance: valid four edges after the grant
    l3_addr0 = 7'd12; l3_req0 = 1'b1;
    tick();
    check("l3_gnt", {127'd0, l3_gnt0}, 128'd1);
    c = 0;
    while (!l3_valid0 && c < 12) begin
      tick();
      c++;
    end
    check("l3_lat", 128'(c), 128'd4);
    check("l3_data", {120'd0, l3_data[7:0]}, 128'd12);
    check("l3_err", {127'd0, l3_error}, 128'd0);
    l3_req0 = 1'b0;
    repeat (2) tick();

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
